// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, data and grant signals shared by the four requesters
// and the round-robin mux arbiter.
interface mux4_rr_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]    req;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;
  logic [DW-1:0] d3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] y;
  logic          y_valid;
  logic          busy;

  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, sel, y, y_valid, busy
  );

  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, sel, y, y_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 data mux with a tenure limit.
//
// state | meaning
// IDLE  | no owner, gnt = 0, sel holds its last value
// GRANT | owner sel_q holds the mux, gnt = 1 << sel_q
module mux4_rr_arbiter #(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q;
  logic [DW-1:0] y_q;
  logic          y_valid_q;
  logic [DW-1:0] d_sel;
  logic [3:0]    own_mask;
  logic [3:0]    others;

  // First set bit of m searching upward from the slot after last.
  function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && m[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign own_mask = 4'b0001 << sel_q;
  assign others   = bus.req & ~own_mask;

  // Next owner, tenure count and grant outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d = GRANT;
          sel_d   = rr_pick(bus.req, last_q);
          gnt_d   = 4'b0001 << sel_d;
          last_d  = sel_d;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          if (bus.req != 4'b0000) begin
            sel_d  = rr_pick(bus.req, last_q);
            gnt_d  = 4'b0001 << sel_d;
            last_d = sel_d;
            cnt_d  = 4'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = 4'd0;
          // Tenure expired: hand over only if someone else is waiting.
          if (others != 4'b0000) begin
            sel_d  = rr_pick(others, last_q);
            gnt_d  = 4'b0001 << sel_d;
            last_d = sel_d;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Arbitration state and registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == GRANT);
    end
  end

  // Data word of the current owner.
  always_comb begin
    d_sel = bus.d0;
    unique case (sel_q)
      2'd0: d_sel = bus.d0;
      2'd1: d_sel = bus.d1;
      2'd2: d_sel = bus.d2;
      2'd3: d_sel = bus.d3;
      default: d_sel = bus.d0;
    endcase
  end

  // Capture owner data while it is still requesting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if ((gnt_q != 4'b0000) && bus.req[sel_q]) begin
      y_q       <= d_sel;
      y_valid_q <= 1'b1;
    end else begin
      y_valid_q <= 1'b0;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: cycle model plus directed scenarios.
module tb_mux4_rr_arbiter;

  localparam int DW       = 8;
  localparam int HOLD_MAX = 4;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if #(.DW(DW)) bus ();

  mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 when idle), cycles held so far, last owner.
  int            m_owner;
  int            m_last;
  int            m_held;
  int            m_sel;
  logic [DW-1:0] m_y;
  logic          m_yv;
  bit            m_live = 1'b0;

  function automatic int rr(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (m[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] dword(input int i);
    case (i)
      0: return bus.d0;
      1: return bus.d1;
      2: return bus.d2;
      default: return bus.d3;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] r;
    logic [3:0] oth;
    int         o;
    r = bus.req;
    m_live = 1'b1;
    if (!rst_n) begin
      m_owner = -1; m_last = 3; m_held = 0; m_sel = 0; m_y = '0; m_yv = 1'b0;
    end else begin
      if (m_owner >= 0 && r[m_owner]) begin
        m_y  = dword(m_owner);
        m_yv = 1'b1;
      end else begin
        m_yv = 1'b0;
      end
      o = -2;
      if (m_owner < 0 || !r[m_owner]) begin
        if (r != 4'b0000) o = rr(r, m_last);
        else m_owner = -1;
      end else begin
        oth = r & ~(4'b0001 << m_owner);
        if (m_held >= HOLD_MAX && oth != 4'b0000) o = rr(oth, m_last);
        else if (m_held >= HOLD_MAX) m_held = 1;
        else m_held++;
      end
      if (o >= 0) begin
        m_owner = o; m_last = o; m_sel = o; m_held = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_gnt", bus.gnt, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("m_sel", bus.sel, m_sel);
      chk("m_busy", bus.busy, m_owner >= 0);
      chk("m_y_valid", bus.y_valid, m_yv);
      chk("m_y", bus.y, m_y);
      chk("onehot", $countones(bus.gnt) <= 1, 1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    bus.d0  = 8'h11;
    bus.d1  = 8'hA5;
    bus.d2  = 8'h22;
    bus.d3  = 8'h33;

    // Reset held with all requests asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_sel", bus.sel, 0);
      chk("rst_y", bus.y, 0);
      chk("rst_yv", bus.y_valid, 0);
      chk("rst_busy", bus.busy, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("first_gnt", bus.gnt, 4'b0001);

    // Full contention: 4 cycles each, owners 0,1,2,3,0.
    for (int i = 0; i < 20; i++) begin
      chk("rot_gnt", bus.gnt, 32'd1 << ((i / 4) % 4));
      chk("rot_sel", bus.sel, (i / 4) % 4);
      if (i >= 1) chk("rot_yv", bus.y_valid, 1);
      tick();
    end

    // Single requester holds well past the tenure limit.
    rst_n = 1'b0; bus.req = 4'b0000;
    tick();
    chk("rst2_busy", bus.busy, 0);
    rst_n = 1'b1; bus.req = 4'b0010;
    tick();
    chk("single_gnt", bus.gnt, 4'b0010);
    chk("single_sel", bus.sel, 1);
    chk("single_yv0", bus.y_valid, 0);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("single_hold", bus.gnt, 4'b0010);
      chk("single_y", bus.y, 8'hA5);
      chk("single_yv", bus.y_valid, 1);
    end

    // Early release by owner 0 while requester 2 waits.
    rst_n = 1'b0; bus.req = 4'b0000;
    tick();
    rst_n = 1'b1; bus.req = 4'b0101;
    tick();
    chk("er_gnt0", bus.gnt, 4'b0001);
    tick();
    chk("er_y0", bus.y, 8'h11);
    bus.req = 4'b0100;
    tick();
    chk("er_gnt2", bus.gnt, 4'b0100);
    chk("er_busy", bus.busy, 1);
    chk("er_gap", bus.y_valid, 0);
    tick();
    chk("er_y2", bus.y, 8'h22);
    chk("er_yv2", bus.y_valid, 1);

    // Hand to requester 0, then everyone drops.
    bus.req = 4'b0001;
    tick();
    chk("drop_gnt0", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    tick();
    chk("drop_gnt", bus.gnt, 0);
    chk("drop_busy", bus.busy, 0);
    tick();
    chk("drop_yv", bus.y_valid, 0);
    chk("drop_yhold", bus.y, 8'h22);
    chk("drop_sel", bus.sel, 0);
    bus.req = 4'b0011;
    tick();
    chk("after_last0", bus.gnt, 4'b0010);

    // Requester 2 owns, then a one-cycle reset.
    bus.req = 4'b0100;
    tick();
    chk("mr_gnt2", bus.gnt, 4'b0100);
    rst_n = 1'b0; bus.req = 4'b0101;
    tick();
    chk("mr_gnt", bus.gnt, 0);
    chk("mr_sel", bus.sel, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_yv", bus.y_valid, 0);
    chk("mr_y", bus.y, 0);
    rst_n = 1'b1;
    tick();
    chk("mr_regnt", bus.gnt, 4'b0001);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for a shared 4-to-1 data mux. Four requesters compete for the mux output; the block picks one owner, drives the one-hot grant and the 2-bit mux select, and registers the selected data word with a valid strobe. A tenure limit stops one requester from holding the mux while others wait.

## Interface
Parameters:
- DW, 8, data width of each input word and of `y`.
- HOLD_MAX, 4, maximum consecutive cycles one owner holds the grant while another requester is waiting. Legal range is 1..16; the tenure counter is 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  4  request per requester; bit i belongs to requester i.
- d0, d1, d2, d3  input  DW each  data words of requesters 0..3.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered mux select; the encoded index of `gnt`.
- y  output  DW  registered data of the current owner.
- y_valid  output  1  registered; high when `y` was captured this edge.
- busy  output  1  registered; high while any grant is active.

## Operation
- Two states:
  - IDLE: `gnt` is 0.
  - GRANT: owner o, with `gnt` = 1<<o and `sel` = o.
- Internal state:
  - last: 2-bit index of the most recent owner; reset value 3.
  - cnt: tenure counter; reset value 0.
- Round-robin pick from a request mask m: the first set bit of m, searching indices (last+1), (last+2), (last+3), (last+4) mod 4.
- IDLE, each edge:
  - If req != 0: enter GRANT with o = pick(req), set last = o and cnt = 0.
  - Otherwise stay in IDLE.
- GRANT with owner o, each edge, first matching rule wins:
  1. req[o] == 0 (release):
     - If req != 0: grant pick(req), set last = new owner, cnt = 0.
     - Otherwise: go to IDLE; `gnt`, `sel` and `busy` clear and last keeps o.
  2. req[o] == 1, cnt == HOLD_MAX-1, and (req & ~(1<<o)) != 0 (tenure expired): grant pick(req & ~(1<<o)), cnt = 0.
  3. req[o] == 1, cnt == HOLD_MAX-1, no other request: keep o, cnt = 0.
  4. Otherwise: keep o, cnt = cnt+1.
- Data path, each edge:
  - If gnt != 0 and req[sel] == 1: y <= d[sel] and y_valid <= 1.
  - Otherwise: y_valid <= 0 and y holds its value.
- `sel` always matches `gnt`. While idle, `sel` holds its last value.
- Requests may change on any cycle. A request that drops before it is granted is simply not considered; nothing is latched.

## Timing
- Reset values, after an edge with rst_n = 0: gnt = 0, sel = 0, y = 0, y_valid = 0, busy = 0, state IDLE, last = 3, cnt = 0. The first grant after reset therefore favours requester 0.
- Reset has priority over every other event, including in the middle of a grant. Outputs take their reset values on that same edge.
- req sampled at edge k gives gnt/sel/busy at edge k (visible in cycle k+1). That is a 1-cycle request-to-grant latency.
- y/y_valid are sampled from the cycle-(k+1) grant at edge k+1. That is 2 cycles from request to first data.
- Handover between owners has no idle cycle: the release or expiry edge loads the next owner directly.
- Under continuous contention each owner holds exactly HOLD_MAX cycles. With HOLD_MAX=1 the grant rotates every cycle.
- A lone requester keeps the grant indefinitely. cnt wraps to 0 every HOLD_MAX cycles and the grant does not drop.
- At most one `gnt` bit is set in any cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111. Required: gnt=0, sel=0, y=0, y_valid=0, busy=0 throughout. After release, the first grant is gnt=4'b0001.
- Single requester: d1=8'hA5, req=4'b0010 from cycle 0. Required: gnt=4'b0010 and sel=2'b01 from cycle 1; y=8'hA5 with y_valid=1 from cycle 2; grant held for 12 cycles, past HOLD_MAX.
- Full contention (HOLD_MAX=4): req=4'b1111 held constant. Required: owners 0,1,2,3,0 in turn, each for exactly 4 cycles; `gnt` stays one-hot; y_valid stays 1 after the first data edge.
- Early release: owner 0 drops req after 2 cycles while req[2] is high. Required: the next edge grants 4'b0100 with no idle cycle, and y_valid shows a 1-cycle gap.
- All requests drop: req goes to 0 during a grant. Required: the next edge gives gnt=0 and busy=0, then y_valid=0 one edge later and y holds its last value. A later req=4'b0011 with last=0 grants requester 1.
- Mid-grant reset: assert rst_n=0 for 1 cycle while requester 2 owns the grant. Required: all outputs are at reset values on that edge, and the following grant goes to requester 0 when req=4'b0101.
